// File: rtl/rgb_pwm_gen.sv
// rgb_pwm_gen: self-timed N-channel PWM generator with its own period counter,
// edge- or centre-aligned counting, and double-buffered channel levels that
// are applied together at a period boundary.
module rgb_pwm_gen #(
    parameter int unsigned PWM_WIDTH = 12,
    parameter int unsigned CHANNELS  = 3,
    parameter bit          CENTER    = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          load,
    input  logic [CHANNELS*PWM_WIDTH-1:0] levels,
    output logic [CHANNELS-1:0]           pwm_out,
    output logic                          period_start,
    output logic [PWM_WIDTH-1:0]          count,
    output logic                          pending
);

    localparam logic [PWM_WIDTH-1:0] MAX = '1;
    localparam logic [PWM_WIDTH-1:0] ONE = PWM_WIDTH'(1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    dir_e                          dir_q,     dir_d;
    logic [PWM_WIDTH-1:0]          count_q,   count_d;
    logic [CHANNELS*PWM_WIDTH-1:0] active_q,  active_d;
    logic [CHANNELS*PWM_WIDTH-1:0] pend_q,    pend_d;
    logic                          pending_q, pending_d;
    logic [CHANNELS-1:0]           pwm_q,     pwm_d;
    logic                          ps_q,      ps_d;
    logic                          wrap;

    // Counter sequencing, compare, and level buffer update for the next cycle.
    always_comb begin
        count_d   = count_q;
        dir_d     = dir_q;
        active_d  = active_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        pwm_d     = '0;
        ps_d      = 1'b0;
        wrap      = 1'b0;

        if (enable) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                pwm_d[i] = (active_q[i*PWM_WIDTH +: PWM_WIDTH] > count_q);
            end
            // count==0 only ever occurs at the first cycle of a period
            ps_d = (count_q == '0);

            if (CENTER) begin
                if (dir_q == DIR_UP) begin
                    if (count_q == MAX) begin
                        dir_d   = DIR_DOWN;
                        count_d = count_q - ONE;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end else begin
                    count_d = count_q - ONE;
                    if (count_q == ONE) begin
                        dir_d = DIR_UP;
                        wrap  = 1'b1;
                    end
                end
            end else begin
                if (count_q == MAX) begin
                    count_d = '0;
                    wrap    = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end
        end else begin
            // Idle: counter parked at 0 and any pending levels applied at once
            count_d = '0;
            dir_d   = DIR_UP;
            wrap    = 1'b1;
        end

        // A load coinciding with a boundary bypasses the pending buffer
        if (load) begin
            pend_d = levels;
            if (wrap) begin
                active_d  = levels;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (wrap && pending_q) begin
            active_d  = pend_q;
            pending_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            dir_q     <= DIR_UP;
            active_q  <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
            pwm_q     <= '0;
            ps_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            dir_q     <= dir_d;
            active_q  <= active_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
            ps_q      <= ps_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign count        = count_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Directed bench for rgb_pwm_gen: an edge-aligned and a centre-aligned
// instance, both W=4 with three channels.
module tb_rgb_pwm_gen;

    logic        clk;
    logic        reset;

    logic        e_enable, e_load;
    logic [11:0] e_levels;
    logic [2:0]  e_pwm;
    logic        e_ps;
    logic [3:0]  e_count;
    logic        e_pending;

    logic        c_enable, c_load;
    logic [11:0] c_levels;
    logic [2:0]  c_pwm;
    logic        c_ps;
    logic [3:0]  c_count;
    logic        c_pending;

    int passed = 0;
    int total  = 0;

    rgb_pwm_gen #(.PWM_WIDTH(4), .CHANNELS(3), .CENTER(1'b0)) u_edge (
        .clk(clk), .reset(reset), .enable(e_enable), .load(e_load),
        .levels(e_levels), .pwm_out(e_pwm), .period_start(e_ps),
        .count(e_count), .pending(e_pending)
    );

    rgb_pwm_gen #(.PWM_WIDTH(4), .CHANNELS(3), .CENTER(1'b1)) u_center (
        .clk(clk), .reset(reset), .enable(c_enable), .load(c_load),
        .levels(c_levels), .pwm_out(c_pwm), .period_start(c_ps),
        .count(c_count), .pending(c_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_e_count(input logic [3:0] target, output bit ok);
        int n = 0;
        while (e_count !== target && n < 40) begin
            tick();
            n++;
        end
        ok = (e_count === target);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({e_count, e_pwm, e_ps, e_pending} !== 9'd0)
            $display("FAIL reset_edge: got count=%0d pwm=%b ps=%b pend=%b, want all 0",
                     e_count, e_pwm, e_ps, e_pending);
        else passed++;
        total++;
        if ({c_count, c_pwm, c_ps, c_pending} !== 9'd0)
            $display("FAIL reset_center: got count=%0d pwm=%b ps=%b pend=%b, want all 0",
                     c_count, c_pwm, c_ps, c_pending);
        else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_edge_duty();
        int h0 = 0, h1 = 0, h2 = 0, nps = 0;
        e_levels = 12'hF05;
        e_load   = 1'b1;
        tick();
        e_load   = 1'b0;
        total++;
        if (e_pending !== 1'b0 || e_count !== 4'd0)
            $display("FAIL idle_load: got pending=%b count=%0d, want 0/0", e_pending, e_count);
        else passed++;
        e_enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) begin
                total++;
                if (e_ps !== 1'b1 || e_count !== 4'd1 || e_pwm !== 3'b101)
                    $display("FAIL edge_first: got ps=%b count=%0d pwm=%b, want 1/1/101",
                             e_ps, e_count, e_pwm);
                else passed++;
            end
            h0 += int'(e_pwm[0]);
            h1 += int'(e_pwm[1]);
            h2 += int'(e_pwm[2]);
            nps += int'(e_ps);
        end
        total++;
        if (h0 != 5 || h1 != 0 || h2 != 15)
            $display("FAIL edge_duty: got high %0d/%0d/%0d, want 5/0/15", h0, h1, h2);
        else passed++;
        total++;
        if (nps != 1)
            $display("FAIL edge_ps_count: got %0d pulses, want 1", nps);
        else passed++;
    endtask

    task automatic test_midperiod_load();
        bit ok;
        int h0 = 0, h2 = 0;
        wait_e_count(4'd7, ok);
        total++;
        if (!ok) $display("FAIL wait7: count=%0d, want 7", e_count);
        else passed++;
        e_levels = 12'hF09;
        e_load   = 1'b1;
        tick();
        e_load   = 1'b0;
        total++;
        if (e_pending !== 1'b1)
            $display("FAIL mid_pending: got %b, want 1", e_pending);
        else passed++;
        wait_e_count(4'd15, ok);
        total++;
        if (!ok || e_pending !== 1'b1 || e_pwm[0] !== 1'b0)
            $display("FAIL mid_hold: count=%0d pending=%b pwm0=%b, want 15/1/0",
                     e_count, e_pending, e_pwm[0]);
        else passed++;
        tick();
        total++;
        if (e_count !== 4'd0 || e_pending !== 1'b0)
            $display("FAIL mid_apply: count=%0d pending=%b, want 0/0", e_count, e_pending);
        else passed++;
        for (int k = 1; k <= 16; k++) begin
            tick();
            h0 += int'(e_pwm[0]);
            h2 += int'(e_pwm[2]);
        end
        total++;
        if (h0 != 9 || h2 != 15)
            $display("FAIL mid_duty: got high %0d/%0d, want 9/15", h0, h2);
        else passed++;
    endtask

    task automatic test_load_at_max();
        bit ok;
        bit seen_pend = 1'b0;
        int h0 = 0;
        wait_e_count(4'd15, ok);
        total++;
        if (!ok) $display("FAIL wait15: count=%0d, want 15", e_count);
        else passed++;
        e_levels = 12'hF03;
        e_load   = 1'b1;
        tick();
        e_load   = 1'b0;
        total++;
        if (e_pending !== 1'b0 || e_count !== 4'd0)
            $display("FAIL max_bypass: pending=%b count=%0d, want 0/0", e_pending, e_count);
        else passed++;
        for (int k = 1; k <= 16; k++) begin
            tick();
            h0 += int'(e_pwm[0]);
            if (e_pending !== 1'b0) seen_pend = 1'b1;
        end
        total++;
        if (h0 != 3 || seen_pend)
            $display("FAIL max_duty: got high=%0d pending_seen=%b, want 3/0", h0, seen_pend);
        else passed++;
    endtask

    task automatic test_disable_pending();
        bit ok;
        int h0;
        wait_e_count(4'd9, ok);
        total++;
        if (!ok) $display("FAIL wait9: count=%0d, want 9", e_count);
        else passed++;
        e_levels = 12'hF07;
        e_load   = 1'b1;
        tick();
        e_load   = 1'b0;
        total++;
        if (e_pending !== 1'b1 || e_count !== 4'd10)
            $display("FAIL dis_pre: pending=%b count=%0d, want 1/10", e_pending, e_count);
        else passed++;
        e_enable = 1'b0;
        tick();
        total++;
        if (e_count !== 4'd0 || e_pwm !== 3'b000 || e_pending !== 1'b0 || e_ps !== 1'b0)
            $display("FAIL dis_idle: count=%0d pwm=%b pend=%b ps=%b, want 0/000/0/0",
                     e_count, e_pwm, e_pending, e_ps);
        else passed++;
        tick();
        total++;
        if (e_count !== 4'd0 || e_pwm !== 3'b000)
            $display("FAIL dis_hold: count=%0d pwm=%b, want 0/000", e_count, e_pwm);
        else passed++;
        e_enable = 1'b1;
        tick();
        total++;
        if (e_ps !== 1'b1 || e_count !== 4'd1 || e_pwm !== 3'b101)
            $display("FAIL reenable: ps=%b count=%0d pwm=%b, want 1/1/101",
                     e_ps, e_count, e_pwm);
        else passed++;
        h0 = int'(e_pwm[0]);
        for (int k = 2; k <= 16; k++) begin
            tick();
            h0 += int'(e_pwm[0]);
        end
        total++;
        if (h0 != 7)
            $display("FAIL reenable_duty: got high=%0d, want 7", h0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int hp = 0, nps = 0;
        wait_e_count(4'd8, ok);
        total++;
        if (!ok) $display("FAIL wait8: count=%0d, want 8", e_count);
        else passed++;
        reset    = 1'b1;
        e_levels = 12'hF0A;
        e_load   = 1'b1;
        tick();
        reset    = 1'b0;
        e_load   = 1'b0;
        total++;
        if ({e_count, e_pwm, e_ps, e_pending} !== 9'd0)
            $display("FAIL reset_mid: count=%0d pwm=%b ps=%b pend=%b, want all 0",
                     e_count, e_pwm, e_ps, e_pending);
        else passed++;
        for (int k = 1; k <= 16; k++) begin
            tick();
            hp += int'(e_pwm[0]) + int'(e_pwm[1]) + int'(e_pwm[2]);
            nps += int'(e_ps);
        end
        total++;
        if (hp != 0 || nps != 1)
            $display("FAIL reset_discard: high=%0d ps=%0d, want 0/1", hp, nps);
        else passed++;
    endtask

    task automatic test_center();
        int h0 = 0, nps = 0, bad = 0;
        logic [3:0] exp_cnt;
        c_levels = 12'h004;
        c_load   = 1'b1;
        tick();
        c_load   = 1'b0;
        c_enable = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp_cnt = (k <= 15) ? 4'(k) : 4'(30 - k);
            if (c_count !== exp_cnt) begin
                if (bad == 0)
                    $display("FAIL center_seq: step %0d count=%0d, want %0d", k, c_count, exp_cnt);
                bad++;
            end
            h0 += int'(c_pwm[0]);
            nps += int'(c_ps);
        end
        total++;
        if (bad != 0) ; else passed++;
        total++;
        if (h0 != 7)
            $display("FAIL center_duty: got high=%0d, want 7", h0);
        else passed++;
        total++;
        if (nps != 1)
            $display("FAIL center_ps: got %0d pulses, want 1", nps);
        else passed++;
        tick();
        total++;
        if (c_ps !== 1'b1 || c_pwm[0] !== 1'b1 || c_count !== 4'd1)
            $display("FAIL center_wrap: ps=%b pwm0=%b count=%0d, want 1/1/1",
                     c_ps, c_pwm[0], c_count);
        else passed++;
    endtask

    initial begin
        reset    = 1'b0;
        e_enable = 1'b0;
        e_load   = 1'b0;
        e_levels = '0;
        c_enable = 1'b0;
        c_load   = 1'b0;
        c_levels = '0;
        test_reset();
        test_edge_duty();
        test_midperiod_load();
        test_load_at_max();
        test_disable_pending();
        test_reset_mid();
        test_center();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
